// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: requester count,
// select width, FSM state encodings and a one-hot helper.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: searches ptr+1 .. ptr+4 (mod 4) and
// returns the first index with its request set.
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    // k = N_REQ wraps back to ptr itself, so the last owner is checked last
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer in front of a 4:1 one-bit mux; owns the mux
// select and registers the selected bit. Optional lock input: MUX_ARB_LOCK_EN.
//
// state    | meaning
// ST_IDLE  | no grant active, gnt=0, busy=0, q=0
// ST_GRANT | one requester owns the mux, q follows d[sel] one cycle late
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             q,
  output logic             busy
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic             lock
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             q_q, q_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_ovr;
  logic             hold_exp;
  logic             release_now;

`ifdef MUX_ARB_LOCK_EN
  assign hold_ovr = lock;
`else
  assign hold_ovr = 1'b0;
`endif

  // ptr always equals sel while granting, so one picker serves both cases
  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hold_exp    = (hold_cnt_q == HOLD_LAST) && !hold_ovr;
  assign release_now = !req[sel_q] || hold_exp;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    q_d        = q_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          ptr_d      = pick_idx;
          sel_d      = pick_idx;
          gnt_d      = onehot(pick_idx);
          hold_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end

      ST_GRANT: begin
        q_d = d[sel_q];
        if (release_now) begin
          if (pick_any) begin
            ptr_d      = pick_idx;
            sel_d      = pick_idx;
            gnt_d      = onehot(pick_idx);
            hold_cnt_d = '0;
            busy_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            q_d     = 1'b0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          // saturates when lock holds the grant past its limit
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        q_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= SEL_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      q_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign q    = q_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed vectors push expected
// {gnt,sel,q,busy} per edge; a negedge monitor pops and compares.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       q;
  logic       busy;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
    logic       chk_hold;
    logic [3:0] hold;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  rr_mux_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .q     (q),
    .busy  (busy)
`ifdef MUX_ARB_LOCK_EN
    ,
    .lock  (lock)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if ({gnt, sel, q, busy} !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s: gnt/sel/q/busy got %b/%b/%b/%b expected %b/%b/%b/%b at %0t",
                 mon_e.name, gnt, sel, q, busy,
                 mon_e.exp[7:4], mon_e.exp[3:2], mon_e.exp[1], mon_e.exp[0], $time);
      end
      if (mon_e.chk_hold) begin
        n_checks++;
        if (dut.hold_cnt_q !== mon_e.hold) begin
          n_fail++;
          $display("FAIL %s_hold: hold_cnt got %0d expected %0d at %0t",
                   mon_e.name, dut.hold_cnt_q, mon_e.hold, $time);
        end
      end
    end
  end

  task automatic chk_now(input string nm, input logic [7:0 ] exp_v);
    n_checks++;
    if ({gnt, sel, q, busy} !== exp_v) begin
      n_fail++;
      $display("FAIL %s: gnt/sel/q/busy got %b/%b/%b/%b expected %b/%b/%b/%b",
               nm, gnt, sel, q, busy, exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  // Drive inputs for the coming edge, then queue what must appear after it.
  task automatic step(input string nm, input logic [3:0] r, input logic [3:0] dv,
                      input logic [3:0] eg, input logic [1:0] es, input logic eq,
                      input logic eb, input logic ch = 1'b0, input logic [3:0] eh = 4'd0);
    exp_t e;
    req = r;
    d   = dv;
    @(posedge clk);
    e.name     = nm;
    e.exp      = {eg, es, eq, eb};
    e.chk_hold = ch;
    e.hold     = eh;
    sb_q.push_back(e);
    #1;
  endtask

  initial begin
    logic [3:0] dv2;
    logic [3:0] one;
    rst_n = 1'b1;
    req   = 4'b0000;
    d     = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2 chk_now("reset_init", 8'b0000_00_0_0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Grant, then async reset in the middle of it
    step("pre_rst_a", 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
    step("pre_rst_b", 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_now("reset_mid_grant", 8'b0000_00_0_0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full rotation with all requesting; first winner must be 0 again
    dv2 = 4'b0101;
    one = 4'b0001;
    for (int e = 1; e <= 40; e++) begin
      int own, prv;
      logic eqv;
      own = ((e - 1) / 8) % 4;
      prv = (e < 2) ? 0 : ((e - 2) / 8) % 4;
      eqv = (e == 1) ? 1'b0 : dv2[prv];
      step("rotate", 4'b1111, dv2, one << own, own[1:0], eqv, 1'b1);
    end
    step("rotate_idle", 4'b0000, dv2, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single short request on 2
    step("single2_a", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
    step("single2_b", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step("single2_c", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step("single2_drop", 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("single2_idle", 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Sole requester 1 re-granted at every expiry without a gap
    for (int e = 1; e <= 20; e++) begin
      int h;
      h = (e - 1) % 8;
      step("sole1", 4'b0010, 4'b0010, 4'b0010, 2'd1, (e == 1) ? 1'b0 : 1'b1, 1'b1,
           1'b1, h[3:0]);
    end
    step("sole1_drop", 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner drops while others raise
    step("swap_a", 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);
    step("swap_b", 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1);
    step("swap_c", 4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b1);
    step("swap_d", 4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1);
    step("swap_e", 4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    step("swap_f", 4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1);
    step("swap_idle", 4'b0000, 4'b1010, 4'b0000, 2'd3, 1'b0, 1'b0);

`ifdef MUX_ARB_LOCK_EN
    lock = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      int h;
      h = (e - 1 > 7) ? 7 : e - 1;
      step("lock0", 4'b0011, 4'b0011, 4'b0001, 2'd0, (e == 1) ? 1'b0 : 1'b1, 1'b1,
           1'b1, h[3:0]);
    end
    lock = 1'b0;
    step("unlock_move", 4'b0011, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 4'd0);
    step("unlock_idle", 4'b0000, 4'b0011, 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
